mrv32_bpred: RTL

MRV32_BPRED -- requirements
Module: mrv32_bpred

---
 rtl/mrv32_pkg.sv | 31 +++
 rtl/mrv32_bpred_table.sv | 101 ++++++++++
 rtl/mrv32_bpred.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mrv32_pkg.sv
// Shared types for the mrv32 branch predictor: branch-select codes, table
// update operations and the table entry layout.
package mrv32_pkg;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_JUMP = 2'b01,
      BR_EQZ  = 2'b10,
      BR_NEZ  = 2'b11
   } br_sel_e;

   typedef enum logic [1:0] {
      UPD_COND_T  = 2'b00,
      UPD_COND_NT = 2'b01,
      UPD_JUMP    = 2'b10,
      UPD_INVAL   = 2'b11
   } upd_op_e;

   localparam int CTR_W_MAX = 4;
   localparam int TAG_W_MAX = 32;

   // Fields are sized for the largest legal configuration; narrower tables
   // return their contents zero-extended.
   typedef struct packed {
      logic                 valid;
      logic [CTR_W_MAX-1:0] ctr;
      logic [TAG_W_MAX-1:0] tag;
      logic [29:0]          target;
   } bpred_entry_t;

endpackage

// File: rtl/mrv32_bpred_table.sv
// Predictor storage: one asynchronous read port for fetch lookup and one
// update port that applies the counter/allocation rules at the resolve index.
module mrv32_bpred_table
   import mrv32_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int CTR_W   = 2,
   parameter int TAG_W   = 8,
   parameter int IDX_W   = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IDX_W-1:0]   rd_idx,
   output bpred_entry_t       rd_entry,
   input  logic               upd_valid,
   input  upd_op_e            upd_op,
   input  logic [IDX_W-1:0]   upd_idx,
   input  logic [TAG_W-1:0]   upd_tag,
   input  logic [29:0]        upd_target
);

   localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(1) << (CTR_W - 1);
   localparam logic [CTR_W-1:0] WEAK_NT = WEAK_T - CTR_W'(1);

   logic             valid_q [ENTRIES];
   logic [CTR_W-1:0] ctr_q   [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [29:0]      tgt_q   [ENTRIES];

   logic             hit;
   logic [CTR_W-1:0] cur;
   logic             valid_we, ctr_we, meta_we, valid_nxt;
   logic [CTR_W-1:0] ctr_nxt;

   always_comb begin
      rd_entry        = '0;
      rd_entry.valid  = valid_q[rd_idx];
      rd_entry.ctr    = CTR_W_MAX'(ctr_q[rd_idx]);
      rd_entry.tag    = TAG_W_MAX'(tag_q[rd_idx]);
      rd_entry.target = tgt_q[rd_idx];
   end

   assign hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign cur = ctr_q[upd_idx];

   always_comb begin
      valid_we  = 1'b0;
      ctr_we    = 1'b0;
      meta_we   = 1'b0;
      valid_nxt = 1'b1;
      ctr_nxt   = cur;
      if (upd_valid) begin
         case (upd_op)
            UPD_JUMP: begin
               valid_we = 1'b1;
               ctr_we   = 1'b1;
               meta_we  = 1'b1;
               ctr_nxt  = CTR_MAX;
            end
            UPD_COND_T: begin
               valid_we = 1'b1;
               ctr_we   = 1'b1;
               meta_we  = 1'b1;
               // A fresh allocation starts weakly taken.
               if (!hit)                ctr_nxt = WEAK_T;
               else if (cur != CTR_MAX) ctr_nxt = cur + CTR_W'(1);
            end
            UPD_COND_NT: begin
               ctr_we = hit;
               if (cur != '0) ctr_nxt = cur - CTR_W'(1);
            end
            UPD_INVAL: begin
               valid_we  = hit;
               valid_nxt = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= WEAK_NT;
         end
      end else begin
         if (valid_we) valid_q[upd_idx] <= valid_nxt;
         if (ctr_we)   ctr_q[upd_idx]   <= ctr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (meta_we) begin
         tag_q[upd_idx] <= upd_tag;
         tgt_q[upd_idx] <= upd_target;
      end
   end

endmodule

// File: rtl/mrv32_bpred.sv
// Branch predictor and resolver: combinational fetch lookup, branch outcome
// resolution, registered mispredict redirect and saturating perf counters.
module mrv32_bpred
   import mrv32_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int CTR_W   = 2,
   parameter int TAG_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   input  logic [31:0] if_pc,
   output logic        if_pred_taken,
   output logic [31:0] if_pred_target,
   input  logic        rs_valid,
   input  logic [31:0] rs_pc,
   input  logic [1:0]  rs_br_sel,
   input  logic [31:0] rs_alu_result,
   input  logic [31:0] rs_target,
   input  logic        rs_pred_taken,
   input  logic [31:0] rs_pred_target,
   output logic        take_branch,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [31:0] perf_branches,
   output logic [31:0] perf_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_HI = IDX_W + TAG_W + 1;
   localparam logic [CTR_W_MAX-1:0] CTR_HALF = CTR_W_MAX'(1 << (CTR_W - 1));

   br_sel_e      br;
   bpred_entry_t rd_entry;
   logic         is_branch, mispredict, upd_valid;
   upd_op_e      upd_op;
   logic [31:0]  fix_pc;
   logic [TAG_W-1:0] if_tag;
   logic         unused_bits;

   assign br     = br_sel_e'(rs_br_sel);
   assign if_tag = if_pc[TAG_HI:IDX_W+2];

   assign unused_bits = ^{if_pc[31:TAG_HI+1], if_pc[1:0],
                          rs_pc[31:TAG_HI+1], rs_pc[1:0]};

   mrv32_bpred_table #(
      .ENTRIES (ENTRIES),
      .CTR_W   (CTR_W),
      .TAG_W   (TAG_W),
      .IDX_W   (IDX_W)
   ) u_table (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx     (if_pc[IDX_W+1:2]),
      .rd_entry   (rd_entry),
      .upd_valid  (upd_valid),
      .upd_op     (upd_op),
      .upd_idx    (rs_pc[IDX_W+1:2]),
      .upd_tag    (rs_pc[TAG_HI:IDX_W+2]),
      .upd_target (rs_target[31:2])
   );

   assign if_pred_taken  = if_valid && rd_entry.valid &&
                           (rd_entry.tag == TAG_W_MAX'(if_tag)) &&
                           (rd_entry.ctr >= CTR_HALF);
   assign if_pred_target = {rd_entry.target, 2'b00};

   always_comb begin
      take_branch = 1'b0;
      if (rs_valid) begin
         case (br)
            BR_JUMP: take_branch = 1'b1;
            BR_EQZ:  take_branch = (rs_alu_result == 32'd0);
            BR_NEZ:  take_branch = (rs_alu_result != 32'd0);
            default: take_branch = 1'b0;
         endcase
      end
   end

   assign is_branch = rs_valid && (br != BR_NONE);
   assign fix_pc    = take_branch ? rs_target : (rs_pc + 32'd4);

   always_comb begin
      mispredict = 1'b0;
      upd_valid  = 1'b0;
      upd_op     = UPD_COND_NT;
      if (is_branch) begin
         mispredict = (take_branch != rs_pred_taken) ||
                      (take_branch && rs_pred_taken && (rs_target != rs_pred_target));
         upd_valid  = 1'b1;
         if (br == BR_JUMP)    upd_op = UPD_JUMP;
         else if (take_branch) upd_op = UPD_COND_T;
         else                  upd_op = UPD_COND_NT;
      end else if (rs_valid && rs_pred_taken) begin
         // Predicted taken on a non-branch: the entry aliased, so drop it.
         mispredict = 1'b1;
         upd_valid  = 1'b1;
         upd_op     = UPD_INVAL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid   <= 1'b0;
         redirect_pc      <= 32'd0;
         perf_branches    <= 32'd0;
         perf_mispredicts <= 32'd0;
      end else begin
         redirect_valid <= mispredict;
         if (mispredict) redirect_pc <= fix_pc;
         if (is_branch && (perf_branches != 32'hFFFF_FFFF))
            perf_branches <= perf_branches + 32'd1;
         if (mispredict && (perf_mispredicts != 32'hFFFF_FFFF))
            perf_mispredicts <= perf_mispredicts + 32'd1;
      end
   end

endmodule
